// File: rtl/vive_pkg.sv
// Shared definitions for the pulse timestamper: default field widths,
// synchronizer latency, FSM state encoding and the record layout.
package vive_pkg;

    localparam int TS_WIDTH_DEF   = 32;
    localparam int WIDTH_BITS_DEF = 16;
    localparam int MIN_PULSE_DEF  = 3;
    localparam int FIFO_DEPTH_DEF = 4;

    // Cycles between envelope_in being captured by the first synchronizer
    // flop and the FSM seeing it; subtracted from the counter at the edge.
    localparam int SYNC_LATENCY = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HIGH = 1'b1
    } pulse_state_e;

    // Record layout for the default widths: timestamp in the upper bits,
    // width in the lower bits. Other widths keep the same {ts, width} order.
    typedef struct packed {
        logic [TS_WIDTH_DEF-1:0]   timestamp;
        logic [WIDTH_BITS_DEF-1:0] width;
    } pulse_rec_t;

endpackage

// File: rtl/pulse_fifo.sv
// Synchronous first-word-fall-through queue for pulse records.
// DEPTH must be a power of two and at least 2. A push while full is accepted
// only if a pop happens in the same cycle; otherwise it is ignored.
module pulse_fifo
    import vive_pkg::*;
#(
    parameter int DATA_W = TS_WIDTH_DEF + WIDTH_BITS_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Decide which transfers happen this cycle and advance the pointers.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + (do_push ? (AW+1)'(1) : (AW+1)'(0));
        rd_ptr_d = rd_ptr_q + (do_pop  ? (AW+1)'(1) : (AW+1)'(0));
    end

    // Pointer registers; the queue is emptied by resetting them.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pulse_timestamper.sv
// Photodiode pulse timestamper: synchronizes envelope_in, timestamps each
// rising edge against a free-running counter, measures the high time and
// queues {timestamp, width} records for a valid/ready consumer.
// Optional macro PULSE_TIMESTAMPER_DROP_COUNT_EN enables the saturating
// drop counter; without it drop_count is constant zero.
module pulse_timestamper
    import vive_pkg::*;
#(
    parameter int TS_WIDTH   = TS_WIDTH_DEF,
    parameter int WIDTH_BITS = WIDTH_BITS_DEF,
    parameter int MIN_PULSE  = MIN_PULSE_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk_96MHz,
    input  logic                  reset,
    input  logic                  envelope_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TS_WIDTH-1:0]   out_timestamp,
    output logic [WIDTH_BITS-1:0] out_width,
    output logic [15:0]           drop_count
);

    localparam int                    REC_W     = TS_WIDTH + WIDTH_BITS;
    localparam logic [WIDTH_BITS-1:0] WIDTH_MAX = '1;

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic [1:0]            primed_q, primed_d;
    logic                  armed_q, armed_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    pulse_state_e          state_q, state_d;
    logic [TS_WIDTH-1:0]   pulse_ts_q, pulse_ts_d;
    logic [WIDTH_BITS-1:0] width_q, width_d;

    logic                  record_done;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [REC_W-1:0]      fifo_wdata;
    logic [REC_W-1:0]      fifo_rdata;

    // Next-state logic: synchronizer, counter, arming and the pulse FSM.
    always_comb begin
        sync1_d     = envelope_in;
        sync2_d     = sync1_q;
        primed_d    = {primed_q[0], 1'b1};
        ts_d        = ts_q + TS_WIDTH'(1);
        // Only a genuinely sampled low arms the detector, so a level that is
        // already high when reset releases cannot start a pulse.
        armed_d     = armed_q | (primed_q[1] & ~sync2_q);
        state_d     = state_q;
        pulse_ts_d  = pulse_ts_q;
        width_d     = width_q;
        record_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (armed_q && sync2_q) begin
                    state_d    = ST_HIGH;
                    pulse_ts_d = ts_q - TS_WIDTH'(SYNC_LATENCY);
                    width_d    = WIDTH_BITS'(1);
                end
            end
            ST_HIGH: begin
                if (sync2_q) begin
                    if (width_q != WIDTH_MAX) begin
                        width_d = width_q + WIDTH_BITS'(1);
                    end
                end else begin
                    state_d     = ST_IDLE;
                    record_done = (width_q >= WIDTH_BITS'(MIN_PULSE));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers for synchronizer, counter and pulse tracking.
    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            primed_q   <= 2'b00;
            armed_q    <= 1'b0;
            ts_q       <= '0;
            state_q    <= ST_IDLE;
            pulse_ts_q <= '0;
            width_q    <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            primed_q   <= primed_d;
            armed_q    <= armed_d;
            ts_q       <= ts_d;
            state_q    <= state_d;
            pulse_ts_q <= pulse_ts_d;
            width_q    <= width_d;
        end
    end

    // A finished record enters the queue unless the queue is full and the
    // consumer is not draining it this cycle.
    assign fifo_push  = record_done && (!fifo_full || out_ready);
    assign fifo_wdata = {pulse_ts_q, width_q};

    pulse_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_96MHz),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (out_ready),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid     = !fifo_empty;
    assign out_timestamp = fifo_rdata[REC_W-1:WIDTH_BITS];
    assign out_width     = fifo_rdata[WIDTH_BITS-1:0];

`ifdef PULSE_TIMESTAMPER_DROP_COUNT_EN
    logic        record_drop;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Count records lost to a full queue, saturating at all-ones.
    always_comb begin
        record_drop = record_done && fifo_full && !out_ready;
        drop_cnt_d  = drop_cnt_q;
        if (record_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_pulse_timestamper.sv
// Directed self-checking bench for pulse_timestamper: a default-width
// instance plus an 8-bit timestamp instance for the counter wrap case.
module tb_pulse_timestamper;

`ifdef PULSE_TIMESTAMPER_DROP_COUNT_EN
    localparam int EXP_DROP = 2;
`else
    localparam int EXP_DROP = 0;
`endif

    logic        clk_96MHz   = 1'b0;
    logic        reset       = 1'b1;
    logic        envelope_in = 1'b0;
    logic        out_ready   = 1'b0;
    logic        out_valid;
    logic [31:0] out_timestamp;
    logic [15:0] out_width;
    logic [15:0] drop_count;

    logic        env8   = 1'b0;
    logic        ready8 = 1'b1;
    logic        valid8;
    logic [7:0]  ts8;
    logic [15:0] width8;
    logic [15:0] drop8;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] tb_cnt;
    logic [31:0] st;
    logic [31:0] ts_list [6];

    // Free-running clock
    always #5 clk_96MHz = ~clk_96MHz;

    // Reference count of the DUT timestamp counter
    always @(posedge clk_96MHz) begin
        if (reset) tb_cnt <= 32'd0;
        else       tb_cnt <= tb_cnt + 32'd1;
    end

    pulse_timestamper dut (
        .clk_96MHz     (clk_96MHz),
        .reset         (reset),
        .envelope_in   (envelope_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_timestamp (out_timestamp),
        .out_width     (out_width),
        .drop_count    (drop_count)
    );

    pulse_timestamper #(.TS_WIDTH(8)) dut8 (
        .clk_96MHz     (clk_96MHz),
        .reset         (reset),
        .envelope_in   (env8),
        .out_valid     (valid8),
        .out_ready     (ready8),
        .out_timestamp (ts8),
        .out_width     (width8),
        .drop_count    (drop8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_96MHz);
        #1;
    endtask

    // Drive a pulse of hi sampled cycles starting now; returns the counter
    // value the next edge will sample.
    task automatic applyStimulus(input int hi, output logic [31:0] start_ts);
        start_ts    = tb_cnt;
        envelope_in = 1'b1;
        tick(hi);
        envelope_in = 1'b0;
    endtask

    task automatic waitRecord(input string tag, input logic [31:0] exp_ts,
                              input int exp_w);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick(1);
            n++;
        end
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_ts"}, 64'(out_timestamp), 64'(exp_ts));
        checkOutput({tag, "_width"}, 64'(out_width), 64'(exp_w));
    endtask

    task automatic popRecord();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick(1);
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_drop", 64'(drop_count), 64'd0);
        checkOutput("reset_valid8", 64'(valid8), 64'd0);

        // 8-bit counter: 5-cycle pulse starting at 254 spans the wrap
        while (tb_cnt != 32'd254) tick(1);
        env8 = 1'b1;
        tick(5);
        env8 = 1'b0;
        for (int i = 0; i < 40 && !valid8; i++) tick(1);
        checkOutput("wrap_valid", 64'(valid8), 64'd1);
        checkOutput("wrap_ts", 64'(ts8), 64'd254);
        checkOutput("wrap_width", 64'(width8), 64'd5);
        checkOutput("wrap_drop", 64'(drop8), 64'd0);

        // 50-cycle pulse at counter 1000
        while (tb_cnt != 32'd1000) tick(1);
        applyStimulus(50, st);
        waitRecord("p1000", 32'd1000, 50);
        popRecord();
        checkOutput("p1000_popped", 64'(out_valid), 64'd0);

        // Minimum width boundary
        tick(5);
        applyStimulus(2, st);
        tick(20);
        checkOutput("short2_none", 64'(out_valid), 64'd0);
        applyStimulus(3, st);
        waitRecord("min3", st, 3);
        popRecord();

        // Six pulses with the consumer stalled: four kept, two dropped
        tick(5);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4 + i, ts_list[i]);
            tick(6);
        end
        tick(10);
        checkOutput("stall_drop", 64'(drop_count), 64'(EXP_DROP));
        checkOutput("stall_valid", 64'(out_valid), 64'd1);
        checkOutput("stall_head_ts", 64'(out_timestamp), 64'(ts_list[0]));
        tick(3);
        checkOutput("stall_hold_ts", 64'(out_timestamp), 64'(ts_list[0]));
        checkOutput("stall_hold_w", 64'(out_width), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("order%0d_ts", i), 64'(out_timestamp), 64'(ts_list[i]));
            checkOutput($sformatf("order%0d_w", i), 64'(out_width), 64'(4 + i));
            popRecord();
        end
        checkOutput("stall_drained", 64'(out_valid), 64'd0);

        // Width saturation
        tick(5);
        applyStimulus(70000, st);
        waitRecord("sat", st, 65535);
        popRecord();

        // Reset in the middle of a pulse with the envelope held high
        tick(5);
        envelope_in = 1'b1;
        tick(8);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(15);
        checkOutput("rst_hold_none", 64'(out_valid), 64'd0);
        envelope_in = 1'b0;
        tick(8);
        checkOutput("rst_low_none", 64'(out_valid), 64'd0);
        checkOutput("rst_drop", 64'(drop_count), 64'd0);
        applyStimulus(10, st);
        waitRecord("rst_w10", st, 10);
        popRecord();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
